// File: rtl/stream_arb_rr.sv
// Round-robin valid/ready stream arbiter with zero-latency grant and packet locking.
// Define STREAM_ARB_PKT_LOCK_EN to hold the grant through `last`; otherwise arbitration is per beat.

module stream_arb_rr_lane #(
  parameter int SelBits = 2,
  parameter int Lane    = 0
) (
  input  logic               en,
  input  logic [SelBits-1:0] sel,
  input  logic               out_ready,
  output logic               ready
);
  assign ready = en & (sel == SelBits'(Lane)) & out_ready;
endmodule

module stream_arb_rr #(
  parameter int NumInputs = 4,
  parameter int DataBits  = 8,
  parameter int SelBits   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NumInputs-1:0]          in_valid,
  output logic [NumInputs-1:0]          in_ready,
  input  logic [NumInputs*DataBits-1:0] in_data,
  input  logic [NumInputs-1:0]          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DataBits-1:0]           out_data,
  output logic                          out_last,
  output logic [SelBits-1:0]            out_sel
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [SelBits-1:0] grant_r, grant_nxt;
  logic [SelBits-1:0] ptr, ptr_nxt;
  logic [SelBits-1:0] scan_g, g;
  logic               fire, eff_last;

  // Index arithmetic wraps at NumInputs, never at 2^SelBits.
  function automatic logic [SelBits-1:0] wrap_add(input logic [SelBits-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NumInputs) s = s - NumInputs;
    return SelBits'(s);
  endfunction

  // Descending scan so the smallest rotated distance from ptr wins.
  always_comb begin
    scan_g = ptr;
    for (int k = NumInputs - 1; k >= 0; k--) begin
      if (in_valid[wrap_add(ptr, k)]) scan_g = wrap_add(ptr, k);
    end
  end

  always_comb begin
    g = '0;
    if (rst_n) g = (state == LOCKED) ? grant_r : scan_g;
  end

  // Output decode from the candidate.
  always_comb begin
    out_valid = rst_n & in_valid[g];
    out_data  = in_data[int'(g)*DataBits +: DataBits];
    out_last  = in_last[g];
    out_sel   = g;
  end

  for (genvar i = 0; i < NumInputs; i++) begin : g_lane
    stream_arb_rr_lane #(.SelBits(SelBits), .Lane(i)) u_lane (
      .en        (rst_n),
      .sel       (g),
      .out_ready (out_ready),
      .ready     (in_ready[i])
    );
  end

  assign fire = out_valid & out_ready;
`ifdef STREAM_ARB_PKT_LOCK_EN
  assign eff_last = out_last;
`else
  assign eff_last = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_r;
    ptr_nxt   = ptr;
    if (fire && eff_last) begin
      state_nxt = IDLE;
      ptr_nxt   = wrap_add(g, 1);
    end else if (out_valid && state == IDLE) begin
      // Stall or non-final beat: pin the grant so data stays stable.
      state_nxt = LOCKED;
      grant_nxt = g;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_r <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_nxt;
      grant_r <= grant_nxt;
      ptr     <= ptr_nxt;
    end
  end

endmodule
